// File: rtl/rgmii_byte_unpackager.sv
// Converts 9-bit packaged TX FIFO bytes into a paced RGMII byte stream:
// preamble, SFD, frame data, then an enforced inter-frame gap.
module rgmii_byte_unpackager #(
  parameter logic [1:0] SPEED_CODE_GIGABIT     = 2'd2,
  parameter logic [1:0] SPEED_CODE_100_MEGABIT = 2'd1,
  parameter logic [1:0] SPEED_CODE_10_MEGABIT  = 2'd0,
  parameter int         PREAMBLE_LENGTH        = 7,
  parameter int         IFG_LENGTH             = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] speed_code,
  input  logic [8:0] packaged_data,
  input  logic       packaged_data_valid,
  output logic       packaged_data_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_enable,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_GAP
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PRE_LAST      = 8'(PREAMBLE_LENGTH - 1);
  localparam logic [7:0] IFG_LAST      = 8'(IFG_LENGTH - 1);

  state_t     r_state;
  logic       r_slot;
  logic [7:0] r_cnt;
  logic [1:0] r_speed;
  logic [7:0] r_tx_data;
  logic       r_tx_en;
  logic       r_busy;

  logic w_slot_last;
  logic w_first;
  logic w_ready;

  // The nibble-wide downstream needs two clocks per byte below gigabit;
  // the unused code 3 is treated as a slow link.
  always_comb begin
    w_slot_last = r_slot;
    case (r_speed)
      SPEED_CODE_GIGABIT:                           w_slot_last = 1'b1;
      SPEED_CODE_100_MEGABIT, SPEED_CODE_10_MEGABIT: w_slot_last = r_slot;
      default:                                      w_slot_last = r_slot;
    endcase
  end

  assign w_first = packaged_data[8];

  always_comb begin
    w_ready = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_IDLE:  w_ready = packaged_data_valid && !w_first;
        S_SFD:   w_ready = w_slot_last;
        S_DATA:  w_ready = w_slot_last && packaged_data_valid && !w_first;
        default: w_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_slot    <= 1'b0;
      r_cnt     <= 8'd0;
      r_speed   <= SPEED_CODE_100_MEGABIT;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_slot <= ~r_slot;
      case (r_state)
        S_IDLE: begin
          // First byte stays in the FIFO until the SFD slot consumes it.
          if (packaged_data_valid && w_first) begin
            r_state   <= S_PREAMBLE;
            r_slot    <= 1'b0;
            r_cnt     <= 8'd0;
            r_speed   <= speed_code;
            r_tx_data <= PREAMBLE_BYTE;
            r_tx_en   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_PREAMBLE: begin
          if (w_slot_last) begin
            if (r_cnt == PRE_LAST) begin
              r_state   <= S_SFD;
              r_cnt     <= 8'd0;
              r_tx_data <= SFD_BYTE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_SFD: begin
          if (w_slot_last) begin
            r_state   <= S_DATA;
            r_cnt     <= 8'd0;
            r_tx_data <= packaged_data[7:0];
          end
        end
        S_DATA: begin
          // Store-and-forward upstream: a stall or a new first byte ends the frame.
          if (w_slot_last) begin
            if (packaged_data_valid && !w_first) begin
              r_tx_data <= packaged_data[7:0];
            end else begin
              r_state   <= S_GAP;
              r_cnt     <= 8'd0;
              r_tx_data <= 8'h00;
              r_tx_en   <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (w_slot_last) begin
            if (r_cnt == IFG_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= 8'd0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
          r_tx_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign packaged_data_ready = w_ready;
  assign tx_data             = r_tx_data;
  assign tx_data_enable      = r_tx_en;
  assign busy                = r_busy;

endmodule

// File: tb/tb_rgmii_byte_unpackager.sv
// Scoreboard bench: expected TX bytes/holds and gap lengths are queued as
// frames are driven, and a negedge monitor pops and compares them.
module tb_rgmii_byte_unpackager;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] speed_code;
  logic [8:0] packaged_data;
  logic       packaged_data_valid;
  logic       packaged_data_ready;
  logic [7:0] tx_data;
  logic       tx_data_enable;
  logic       busy;

  rgmii_byte_unpackager dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .speed_code          (speed_code),
    .packaged_data       (packaged_data),
    .packaged_data_valid (packaged_data_valid),
    .packaged_data_ready (packaged_data_ready),
    .tx_data             (tx_data),
    .tx_data_enable      (tx_data_enable),
    .busy                (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int b;
    int hold;
    int zr;
  } exp_t;

  exp_t exp_q[$];
  int   gap_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Queue the line-side image of one frame (w[0] is the first byte).
  task automatic expect_frame(input logic [8:0] w[$], input int hold, input int zr);
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      e.b = 'h55; e.hold = hold; e.zr = (i == 0) ? zr : 0;
      exp_q.push_back(e);
    end
    e.b = 'hD5; e.zr = 0;
    exp_q.push_back(e);
    foreach (w[i]) begin
      e.b = int'(w[i][7:0]);
      exp_q.push_back(e);
    end
    gap_q.push_back(12 * hold);
  endtask

  task automatic drive(input logic [8:0] w[$], input int sw_idx, input logic [1:0] sw_val);
    int t;
    for (int i = 0; i < w.size(); i++) begin
      if (i == sw_idx) speed_code = sw_val;
      packaged_data = w[i];
      packaged_data_valid = 1'b1;
      t = 0;
      do begin @(negedge clock); t++; end while (!packaged_data_ready && t < 200);
      chk("ready_wait", int'(packaged_data_ready), 1);
      @(posedge clock); #1;
    end
    packaged_data_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    do begin @(negedge clock); t++; end
    while ((busy || exp_q.size() != 0 || gap_q.size() != 0) && t < 500);
    @(negedge clock);
    chk("drain_bytes", exp_q.size(), 0);
    chk("drain_gaps", gap_q.size(), 0);
  endtask

  // Monitor state
  int   hold_left = 0;
  int   cur_b = 0;
  int   zrun = 0;
  int   gapcnt = 0;
  logic prev_busy = 1'b0;
  logic prev_en = 1'b0;
  exp_t it;

  always @(negedge clock) begin
    if (!mon_en || !reset_n) begin
      hold_left = 0; gapcnt = 0; prev_busy = 1'b0; prev_en = 1'b0; zrun = 0;
    end else begin
      if (tx_data_enable) begin
        if (hold_left > 0) begin
          chk("hold_byte", int'(tx_data), cur_b);
          hold_left--;
        end else if (exp_q.size() == 0) begin
          chk("unexpected_en", int'(tx_data_enable), 0);
        end else begin
          it = exp_q.pop_front();
          chk("tx_byte", int'(tx_data), it.b);
          if (!prev_en && it.zr != 0) chk("idle_run", zrun, it.zr);
          cur_b = it.b;
          hold_left = it.hold - 1;
        end
        zrun = 0;
      end else begin
        if (hold_left > 0) begin
          chk("hold_en", int'(tx_data_enable), 1);
          hold_left = 0;
        end
        zrun++;
        if (busy) begin
          gapcnt++;
          chk("gap_ready", int'(packaged_data_ready), 0);
          chk("gap_txdata", int'(tx_data), 0);
        end
      end
      if (prev_busy && !busy) begin
        if (gap_q.size() == 0) chk("unexpected_gap", gapcnt, -1);
        else chk("gap_len", gapcnt, gap_q.pop_front());
        gapcnt = 0;
      end
      prev_busy = busy;
      prev_en = tx_data_enable;
    end
  end

  logic [8:0] f[$];
  logic [8:0] g[$];
  logic [8:0] tmp[$];

  initial begin
    int t;
    reset_n = 1'b0;
    speed_code = 2'd2;
    packaged_data = 9'h000;
    packaged_data_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", int'(packaged_data_ready), 0);
    chk("rst_txdata", int'(tx_data), 0);
    chk("rst_en", int'(tx_data_enable), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Gigabit 64-byte frame
    f = {9'h100};
    for (int i = 1; i < 64; i++) f.push_back(9'(i));
    expect_frame(f, 1, 0);
    drive(f, -1, 2'd0);
    drain();

    // 100M 4-byte frame
    speed_code = 2'd1;
    f = {9'h1AA, 9'h0BB, 9'h0CC, 9'h0DD};
    expect_frame(f, 2, 0);
    drive(f, -1, 2'd0);
    drain();

    // Back-to-back gigabit frames: 12 gap slots + 1 idle cycle between them
    speed_code = 2'd2;
    f = {9'h1C0, 9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4};
    g = {9'h1D0, 9'h0D1, 9'h0D2, 9'h0D3};
    expect_frame(f, 1, 0);
    expect_frame(g, 1, 13);
    tmp = {f, g};
    drive(tmp, -1, 2'd0);
    drain();

    // Orphans are consumed silently, then a normal frame
    f = {9'h133, 9'h044, 9'h055};
    expect_frame(f, 1, 0);
    tmp = {9'h011, 9'h022, f};
    drive(tmp, -1, 2'd0);
    drain();

    // Speed switched mid-frame takes effect on the next frame only
    speed_code = 2'd2;
    f = {9'h1E0, 9'h0E1, 9'h0E2, 9'h0E3, 9'h0E4, 9'h0E5, 9'h0E6, 9'h0E7};
    expect_frame(f, 1, 0);
    drive(f, 3, 2'd1);
    drain();
    g = {9'h1F0, 9'h0F1, 9'h0F2};
    expect_frame(g, 2, 0);
    drive(g, -1, 2'd0);
    drain();

    // Reset during the data phase
    mon_en = 1'b0;
    speed_code = 2'd2;
    packaged_data = 9'h1A0;
    packaged_data_valid = 1'b1;
    t = 0;
    do begin @(negedge clock); t++; end while (!packaged_data_ready && t < 200);
    chk("rst_sfd_ready", int'(packaged_data_ready), 1);
    @(posedge clock); #1;
    packaged_data = 9'h0A1;
    @(negedge clock);
    chk("rst_data_en", int'(tx_data_enable), 1);
    chk("rst_data_byte", int'(tx_data), 'hA0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    packaged_data_valid = 1'b0;
    @(negedge clock);
    chk("rst_hold_ready", int'(packaged_data_ready), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst_en", int'(tx_data_enable), 0);
    chk("midrst_ready", int'(packaged_data_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_txdata", int'(tx_data), 0);
    exp_q.delete();
    gap_q.delete();
    @(posedge clock); #1;
    mon_en = 1'b1;
    f = {9'h1B0, 9'h0B1, 9'h0B2};
    expect_frame(f, 1, 0);
    drive(f, -1, 2'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rgmii_byte_unpackager.md
# rgmii_byte_unpackager

Transmit-side counterpart of the RGMII receive byte packager. Accepts 9-bit packaged bytes (bit 8 = first byte of frame) from the TX frame FIFO over a valid/ready handshake. Emits a byte stream with data enable to the RGMII transmitter: 7-byte preamble, SFD, frame bytes, then an enforced inter-frame gap. Pacing is one byte per clock at gigabit and one byte per two clocks at 10/100, because the downstream stage sends nibbles.

## Interface
- SPEED_CODE_GIGABIT, 2, speed code for 1000 Mb/s
- SPEED_CODE_100_MEGABIT, 1, speed code for 100 Mb/s
- SPEED_CODE_10_MEGABIT, 0, speed code for 10 Mb/s
- PREAMBLE_LENGTH, 7, number of 0x55 bytes before SFD (range 1-15)
- IFG_LENGTH, 12, idle byte slots after each frame (range 1-255)
- clock  input  1  TX clock: 125/25/2.5 MHz per speed
- reset_n  input  1  reset, synchronous, active-low
- speed_code  input  2  current link speed, latched at frame start
- packaged_data  input  9  [7:0] byte, [8] first byte of frame
- packaged_data_valid  input  1  packaged_data is valid
- packaged_data_ready  output  1  byte consumed this cycle when valid && ready
- tx_data  output  8  byte to RGMII transmitter
- tx_data_enable  output  1  tx_data is part of a frame (preamble/SFD/data)
- busy  output  1  high in any state other than S_IDLE

## Operation
- States: S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_GAP.
- Byte slot:
  - Gigabit: every cycle is a slot-last cycle.
  - 10/100 and invalid code 3: a 1-bit slot counter toggles each cycle; a slot spans 2 cycles and slot-last is the second.
  - The slot counter is cleared on entry to S_PREAMBLE.
- S_IDLE:
  - valid && data[8]=1: latch speed_code and go to S_PREAMBLE. The byte is not consumed.
  - valid && data[8]=0: ready=1, and the orphan byte is consumed and discarded (resync).
  - Otherwise stay in S_IDLE.
- S_PREAMBLE: output 0x55 with enable=1 for PREAMBLE_LENGTH slots, then go to S_SFD.
- S_SFD:
  - Output 0xD5 with enable=1 for one slot.
  - On slot-last, ready=1: consume the first byte (bit 8 set) into the output register and go to S_DATA.
- S_DATA:
  - Output the registered byte with enable=1.
  - On slot-last with valid && data[8]=0: ready=1, load the next byte, stay in S_DATA.
  - On slot-last with !valid, or valid && data[8]=1: ready=0 and go to S_GAP. The frame ends after the current byte.
  - Upstream is store-and-forward, so valid-low mid-frame is treated as end of frame.
- S_GAP:
  - Output enable=0 and tx_data=0x00 for IFG_LENGTH slots, using the byte counter, then go to S_IDLE.
  - A pending first byte waits, unconsumed.
- ready is combinational from state, slot-last and valid/data[8]; ready is never 1 outside the cases above.
- Byte counter: 8-bit. It is cleared on every state change and compared against the count minus 1 for termination.
- speed_code changes mid-frame are ignored until the next S_IDLE exit.

## Timing
- Reset values:
  - packaged_data_ready=0, tx_data=0x00, tx_data_enable=0, busy=0.
  - State S_IDLE, counters 0.
  - Latched speed = SPEED_CODE_100_MEGABIT.
- tx_data and tx_data_enable are registered. busy is registered.
- Gigabit latency, with the first byte observed in S_IDLE at cycle T:
  - 0x55 is output at T+1..T+7.
  - 0xD5 at T+8, with ready=1 at T+8.
  - First frame byte at T+9.
- 10/100: every output byte is held exactly 2 cycles. The first 0x55 is at T+1..T+2 and the first frame byte at T+17..T+18.
- Frame bytes are back-to-back: no enable deassertion between preamble, SFD and data.
- Minimum gap between frames: IFG_LENGTH slots of enable=0, plus 1 cycle in S_IDLE.
- Reset mid-frame: outputs go to reset values on the next edge. The frame is truncated and the upstream byte is not consumed.

## Test plan
- Gigabit, 64-byte frame (0x100 then 0x01..0x3F), valid held through, then dropped:
  - tx_data shows 7×0x55, then 0xD5, then 0x00..0x3F at 1 byte/cycle with enable=1.
  - Then exactly 12 cycles with enable=0, then busy=0.
- 100M, 4-byte frame 0x1AA, 0xBB, 0xCC, 0xDD: each of 7×0x55, 0xD5, 0xAA, 0xBB, 0xCC, 0xDD is held 2 cycles, followed by a 24-cycle gap.
- Back-to-back frames at gigabit: the second frame's 0x1xx arrives right after the first's last byte.
  - The first frame ends; 12 idle slots follow.
  - The second frame's preamble starts 1 cycle after the gap. No byte is lost; ready is low during the gap.
- Orphan bytes 0x011, 0x022 presented in S_IDLE:
  - Both are consumed with ready=1 and tx_data_enable stays 0.
  - A following 0x133 starts a normal frame.
- speed_code switched from 2 to 1 mid-frame: the current frame keeps 1 byte/cycle; the next frame uses 2 cycles/byte.
- reset_n low for 1 cycle during the data phase: tx_data_enable=0, ready=0 and busy=0 next cycle. A new first byte then produces a full preamble.
